// File: rtl/udp_tx_pkt_buf.sv
// udp_tx_pkt_buf: two-bank ping-pong payload buffer feeding a UDP transmitter.
// The write side fills one bank while the read side streams the other bank out
// word by word, with an inter-frame gap enforced between transmitted packets.
module udp_tx_pkt_buf #(
  parameter int DEPTH_WORDS = 256,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_last,
  input  logic [1:0]  wr_last_bytes,
  output logic        wr_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic [15:0] pkt_sent
);

  // Pointers and word counts must hold 0..DEPTH_WORDS inclusive.
  localparam int PW = $clog2(DEPTH_WORDS) + 1;
  localparam int AW = $clog2(2 * DEPTH_WORDS);
  localparam int LW = PW + 2;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH_WORDS - 1);
  localparam logic [15:0]   IFG_LAST = 16'(IFG_CYCLES);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   mem [2*DEPTH_WORDS];
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full_v;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] words [2];
  logic [15:0]   len [2];
  logic [15:0]   gap_cnt;

  logic          wr_accept;
  logic          commit;
  logic          enter_start;
  logic          rel_bank;
  logic          rd_fire;
  logic [PW-1:0] wr_count;
  logic [2:0]    last_bytes;
  logic [LW-1:0] commit_len;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // A bank is writable only while it holds no committed packet, so writes can
  // never land in the bank the read side is draining.
  assign wr_ready   = ~full_v[wr_bank];
  assign wr_accept  = wr_en & wr_ready;
  assign commit     = wr_accept & (wr_last | (wr_ptr == LAST_PTR));
  assign wr_count   = wr_ptr + PW'(1);
  // A zero byte count on the final word means a full word; an auto-commit
  // without wr_last is always a full word.
  assign last_bytes = (!wr_last || (wr_last_bytes == 2'd0)) ? 3'd4 : {1'b0, wr_last_bytes};
  assign commit_len = {wr_count, 2'b00} - LW'(4) + LW'(last_bytes);
  assign wr_addr    = (wr_bank ? AW'(DEPTH_WORDS) : AW'(0)) + AW'(wr_ptr);
  assign rd_addr    = (rd_bank ? AW'(DEPTH_WORDS) : AW'(0)) + AW'(rd_ptr);
  assign rd_fire    = (state == SEND) & tx_req & (rd_ptr < words[rd_bank]);

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Read FSM next state plus the single-cycle start and bank-release strobes
  always_comb begin
    state_next  = state;
    tx_start_en = 1'b0;
    enter_start = 1'b0;
    rel_bank    = 1'b0;
    case (state)
      IDLE: begin
        if (full_v[rd_bank]) begin
          state_next  = START;
          enter_start = 1'b1;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        state_next  = SEND;
      end
      SEND: begin
        if (tx_done) begin
          state_next = GAP;
          rel_bank   = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt + 16'd1 >= IFG_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-side bookkeeping; the read side's release also clears a full flag here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      wr_bank  <= 1'b0;
      full_v   <= '0;
      words[0] <= '0;
      words[1] <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
    end else begin
      if (wr_accept) begin
        if (commit) begin
          wr_ptr          <= '0;
          wr_bank         <= ~wr_bank;
          full_v[wr_bank] <= 1'b1;
          words[wr_bank]  <= wr_count;
          len[wr_bank]    <= 16'(commit_len);
        end else begin
          wr_ptr <= wr_count;
        end
      end
      if (rel_bank) full_v[rd_bank] <= 1'b0;
    end
  end

  // Payload storage has no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= wr_data;
  end

  // Read side: length latch, synchronous word fetch, packet counter and gap timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      rd_bank     <= 1'b0;
      tx_byte_num <= '0;
      tx_data     <= '0;
      pkt_sent    <= '0;
      gap_cnt     <= '0;
    end else begin
      if (enter_start) begin
        tx_byte_num <= len[rd_bank];
        rd_ptr      <= '0;
      end
      if (rd_fire) begin
        tx_data <= mem[rd_addr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      if (rel_bank) begin
        rd_bank  <= ~rd_bank;
        pkt_sent <= pkt_sent + 16'd1;
        gap_cnt  <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// tb_udp_tx_pkt_buf: vector table, directed corner sequences and a randomized
// writer/reader pair checked against a packet-queue model.
module tb_udp_tx_pkt_buf;

  localparam int DEPTH = 256;
  localparam int IFG   = 12;
  localparam int NPKT  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic [1:0]  wr_last_bytes;
  logic        wr_ready;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;
  logic [15:0] pkt_sent;

  int checks = 0;
  int errors = 0;

  // Reference model state for the randomized phase
  int          expLen[$];
  int          expCnt[$];
  logic [31:0] expWords[$];
  bit          abortRand;

  typedef struct {
    logic        we;
    logic [31:0] d;
    logic        last;
    logic [1:0]  lb;
    logic        req;
    logic        done;
    logic        expStart;
    logic [15:0] expBytes;
    logic [31:0] expData;
    logic        expReady;
    logic [15:0] expPkt;
  } vec_t;

  vec_t vecs[11];

  udp_tx_pkt_buf #(.DEPTH_WORDS(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_last_bytes(wr_last_bytes),
    .wr_ready(wr_ready),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .pkt_sent(pkt_sent)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs through a rising edge, then return everything to idle
  task automatic applyStimulus(input logic we, input logic [31:0] d, input logic last,
                               input logic [1:0] lb, input logic req, input logic done);
    wr_en = we; wr_data = d; wr_last = last; wr_last_bytes = lb;
    tx_req = req; tx_done = done;
    step();
    wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_last_bytes = 2'd0;
    tx_req = 1'b0; tx_done = 1'b0;
  endtask

  task automatic doReset();
    wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_last_bytes = 2'd0;
    tx_req = 1'b0; tx_done = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Wait (bounded) until tx_start_en is seen; n counts edges waited
  task automatic waitStart(input int budget, output int n, output bit seen);
    n = 0;
    while (!tx_start_en && n < budget) begin
      step();
      n++;
    end
    seen = tx_start_en;
  endtask

  function automatic int pktBytes(input int nWords, input logic [1:0] lb);
    int lastBytes;
    lastBytes = (lb == 2'd0) ? 4 : int'(lb);
    return nWords * 4 - (4 - lastBytes);
  endfunction

  function automatic logic [31:0] fillWord(input int i);
    return 32'hA5000000 + 32'(i) * 32'h00010001;
  endfunction

  // Randomized writer and transmitter running concurrently against the queue model
  task automatic runRandom();
    int sent = 0;
    abortRand = 1'b0;
    fork
      begin : writer
        for (int p = 0; p < NPKT && !abortRand; p++) begin
          int          nw;
          logic [1:0]  lb;
          nw = $urandom_range(1, 8);
          lb = 2'($urandom_range(0, 3));
          for (int w = 0; w < nw && !abortRand; w++) begin
            int          waited;
            logic [31:0] d;
            waited = 0;
            while (!wr_ready && waited < 1500) begin
              step();
              waited++;
            end
            if (!wr_ready) begin
              checkOutput("rand wr_ready wait", wr_ready, 1);
              abortRand = 1'b1;
            end else begin
              d = $urandom;
              expWords.push_back(d);
              wr_en = 1'b1; wr_data = d; wr_last = (w == nw - 1);
              wr_last_bytes = (w == nw - 1) ? lb : 2'($urandom_range(0, 3));
              step();
              wr_en = 1'b0; wr_last = 1'b0;
              if ($urandom_range(0, 3) == 0) step();
            end
          end
          if (!abortRand) begin
            expLen.push_back(pktBytes(nw, lb));
            expCnt.push_back(nw);
          end
        end
      end
      begin : reader
        for (int p = 0; p < NPKT && !abortRand; p++) begin
          int          n;
          bit          seen;
          int          len;
          int          cnt;
          logic [31:0] lastWord;
          waitStart(1500, n, seen);
          checkOutput("rand start seen", seen, 1);
          checkOutput("rand model has packet", expLen.size() != 0, 1);
          if (!seen || expLen.size() == 0) begin
            abortRand = 1'b1;
          end else begin
            len = expLen.pop_front();
            cnt = expCnt.pop_front();
            checkOutput("rand byte_num", tx_byte_num, 32'(len));
            step();
            lastWord = '0;
            for (int i = 0; i < cnt; i++) begin
              repeat ($urandom_range(0, 2)) step();
              lastWord = expWords.pop_front();
              tx_req = 1'b1;
              step();
              tx_req = 1'b0;
              checkOutput("rand tx_data", tx_data, lastWord);
            end
            if ($urandom_range(0, 1) == 1) begin
              tx_req = 1'b1;
              step();
              tx_req = 1'b0;
              checkOutput("rand tx_data hold", tx_data, lastWord);
            end
            repeat ($urandom_range(0, 2)) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            sent++;
            checkOutput("rand pkt_sent", pkt_sent, 32'(sent));
          end
        end
      end
    join
  endtask

  initial begin
    int  n;
    bit  seen;
    int  starts;

    // Per-cycle table: three-word packet, its start pulse, five requests, done.
    // The start pulse shows one edge after the commit edge and is taken by the
    // transmitter on the edge after that.
    vecs[0]  = '{1'b1, 32'h11223344, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0,  32'h00000000, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 32'h55667788, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0,  32'h00000000, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 32'h99AABBCC, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0,  32'h00000000, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'd10, 32'h00000000, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd10, 32'h00000000, 1'b1, 16'd0};
    vecs[5]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd10, 32'h11223344, 1'b1, 16'd0};
    vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd10, 32'h55667788, 1'b1, 16'd0};
    vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd10, 32'h99AABBCC, 1'b1, 16'd0};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd10, 32'h99AABBCC, 1'b1, 16'd0};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd10, 32'h99AABBCC, 1'b1, 16'd0};
    vecs[10] = '{1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd10, 32'h99AABBCC, 1'b1, 16'd1};

    // Reset values
    doReset();
    checkOutput("reset wr_ready", wr_ready, 1);
    checkOutput("reset tx_start_en", tx_start_en, 0);
    checkOutput("reset tx_byte_num", tx_byte_num, 0);
    checkOutput("reset tx_data", tx_data, 0);
    checkOutput("reset pkt_sent", pkt_sent, 0);

    // Table-driven basic packet
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].d, vecs[i].last, vecs[i].lb, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d tx_start_en", i), tx_start_en, vecs[i].expStart);
      checkOutput($sformatf("vec%0d tx_byte_num", i), tx_byte_num, vecs[i].expBytes);
      checkOutput($sformatf("vec%0d tx_data", i), tx_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d pkt_sent", i), pkt_sent, vecs[i].expPkt);
    end

    // Back-to-back packets and the inter-frame gap
    doReset();
    applyStimulus(1'b1, 32'h00000001, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000002, 1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000003, 1'b1, 2'd3, 1'b0, 1'b0);
    waitStart(5, n, seen);
    checkOutput("b2b first start", seen, 1);
    checkOutput("b2b first byte_num", tx_byte_num, 8);
    step();
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("b2b pkt_sent 1", pkt_sent, 1);
    waitStart(IFG + 20, n, seen);
    // Edges after tx_done until the pulse shows; the transmitter samples it one edge later
    checkOutput("b2b gap edges", n, IFG + 1);
    checkOutput("b2b second byte_num", tx_byte_num, 3);
    step();
    checkOutput("b2b start one cycle", tx_start_en, 0);
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("b2b pkt_sent 2", pkt_sent, 2);

    // Both banks full: extra write ignored, release reopens the write bank
    doReset();
    applyStimulus(1'b1, 32'hA0A0A0A0, 1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB1B1B1B1, 1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("full wr_ready low", wr_ready, 0);
    checkOutput("full bank0 start", tx_start_en, 1);
    checkOutput("full bank0 byte_num", tx_byte_num, 1);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("full rogue wr_ready", wr_ready, 0);
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("full wr_ready after done", wr_ready, 1);
    waitStart(IFG + 20, n, seen);
    checkOutput("full bank1 start", seen, 1);
    checkOutput("full bank1 byte_num", tx_byte_num, 2);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("full bank1 data", tx_data, 32'hB1B1B1B1);
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    waitStart(IFG + 20, n, seen);
    checkOutput("full refill byte_num", tx_byte_num, 4);
    step();
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("full refill data", tx_data, 32'hCAFEF00D);
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("full pkt_sent", pkt_sent, 3);

    // Auto-commit of a bank filled without wr_last
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, fillWord(i), 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("auto wr_ready", wr_ready, 1);
    waitStart(5, n, seen);
    checkOutput("auto start", seen, 1);
    checkOutput("auto byte_num", tx_byte_num, DEPTH * 4);
    applyStimulus(1'b1, 32'h0BADCAFE, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput($sformatf("auto data %0d", i), tx_data, fillWord(i));
    end
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("auto data hold", tx_data, fillWord(DEPTH - 1));
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    waitStart(IFG + 20, n, seen);
    checkOutput("auto bank1 byte_num", tx_byte_num, 4);
    step();
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("auto bank1 data", tx_data, 32'h0BADCAFE);

    // Reset in the middle of a send
    doReset();
    applyStimulus(1'b1, 32'h12345678, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9ABCDEF0, 1'b1, 2'd0, 1'b0, 1'b0);
    waitStart(5, n, seen);
    step();
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("midrst first data", tx_data, 32'h12345678);
    rst = 1'b1;
    #1;
    checkOutput("midrst tx_start_en", tx_start_en, 0);
    checkOutput("midrst tx_byte_num", tx_byte_num, 0);
    checkOutput("midrst tx_data", tx_data, 0);
    checkOutput("midrst pkt_sent", pkt_sent, 0);
    checkOutput("midrst wr_ready", wr_ready, 1);
    step();
    step();
    rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_start_en) starts++;
    end
    checkOutput("midrst no start", starts, 0);
    applyStimulus(1'b1, 32'h0F0F0F0F, 1'b1, 2'd3, 1'b0, 1'b0);
    waitStart(5, n, seen);
    checkOutput("midrst new byte_num", tx_byte_num, 3);
    step();
    applyStimulus(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("midrst new data", tx_data, 32'h0F0F0F0F);

    // Randomized traffic against the queue model
    doReset();
    runRandom();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_pkt_buf.md
UDP_TX_PKT_BUF -- requirements
Module: udp_tx_pkt_buf

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the words per bank (two banks).
REQ-002 The block SHALL have parameter IFG_CYCLES, default 12, giving the idle cycles between tx_done and the next tx_start_en.
REQ-003 The block SHALL have the following ports, each given as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  32  payload word, byte order [31:24] first.
- wr_last  in  1  marks the final word of a packet.
- wr_last_bytes  in  2  valid bytes in the final word; 0 means 4.
- wr_ready  out  1  current write bank can accept words.
- tx_start_en  out  1  start pulse to the UDP transmitter.
- tx_byte_num  out  16  payload byte count for the transmitter.
- tx_req  in  1  transmitter request for the next data word.
- tx_data  out  32  data word to the transmitter.
- tx_done  in  1  transmitter frame-complete pulse.
- pkt_sent  out  16  count of packets completed.

Function
REQ-004 Two-bank ping-pong buffer: the write side fills bank wr_bank while the read side drains bank rd_bank.
- Per bank: flag full_v, word count, byte length.
REQ-005 wr_ready SHALL be high when full_v[wr_bank] is 0.
- wr_en while wr_ready is 0 SHALL be ignored: no write, no state change.
REQ-006 An accepted write SHALL store wr_data at wr_bank*DEPTH_WORDS + wr_ptr and increment wr_ptr.
REQ-007 Commit on wr_last, or on the DEPTH_WORDS-th word without wr_last (auto-commit):
- set full_v[wr_bank];
- length = words*4 - (4 - lb), where lb = wr_last_bytes, 0 taken as 4; auto-commit lb = 4;
- clear wr_ptr;
- toggle wr_bank.
REQ-008 Read FSM states and transitions:
- IDLE: go to START when full_v[rd_bank] is 1.
- START: go to SEND.
- SEND: go to GAP on tx_done.
- GAP: go to IDLE when the gap counter reaches IFG_CYCLES.
REQ-009 tx_start_en SHALL be high for exactly one cycle, the cycle in which the FSM is in START.
- It SHALL be low in all other states.
REQ-010 tx_byte_num SHALL be loaded with the rd_bank length when the FSM enters START.
- It SHALL hold stable until the FSM leaves SEND.
REQ-011 rd_ptr SHALL be cleared on entry to START.
REQ-012 tx_req sampled high in SEND SHALL return the word at rd_ptr on tx_data at the same clock edge (one-cycle latency) and increment rd_ptr.
- Once rd_ptr equals the word count, further tx_req SHALL leave tx_data and rd_ptr unchanged.
- tx_req outside SEND SHALL be ignored.
REQ-013 tx_done in SEND SHALL:
- clear full_v[rd_bank];
- toggle rd_bank;
- increment pkt_sent (wraps 0xFFFF to 0);
- clear the gap counter.
- tx_done outside SEND SHALL be ignored.
REQ-014 A commit on one bank and a release on the other bank in the same cycle SHALL both take effect.
REQ-015 Memory SHALL use a synchronous read with no read-during-write hazard: writes never target the bank being drained.
REQ-016 tx_byte_num SHALL be 16 bits.
- Its maximum is DEPTH_WORDS*4, which is 1024 at the default.

Reset
REQ-017 While rst is high, the block SHALL hold all of the following (memory contents are undefined):
- FSM in IDLE;
- wr_bank = 0, rd_bank = 0;
- wr_ptr = 0, rd_ptr = 0;
- full_v = 0;
- gap counter = 0;
- tx_start_en = 0, tx_byte_num = 0, tx_data = 0, pkt_sent = 0;
- wr_ready = 1.
REQ-018 Reset asserted mid-write or mid-send SHALL discard every buffered and partial packet.
- No tx_start_en SHALL occur until a new packet is committed after reset.

Verification
REQ-019 Write 3 words (0x11223344, 0x55667788, 0x99AABBCC; wr_last_bytes = 2 on the third) -> tx_start_en pulses one cycle, 2 edges after the commit edge; tx_byte_num = 10.
REQ-020 After start, pulse tx_req 3 times, then 2 more -> tx_data = 0x11223344, 0x55667788, 0x99AABBCC, each one cycle after its tx_req; the extra requests hold 0x99AABBCC.
REQ-021 Commit 2 packets back-to-back, then send tx_done for the first -> the second tx_start_en occurs exactly IFG_CYCLES + 2 cycles after tx_done; pkt_sent = 1 then 2.
REQ-022 Fill both banks with no tx_done -> wr_ready = 0; an extra wr_en write is ignored; after tx_done, wr_ready = 1 the next cycle.
REQ-023 Write 256 words without wr_last -> auto-commit; tx_byte_num = 1024; the next write goes to bank 1.
REQ-024 Assert rst during SEND after 1 tx_req -> all outputs return to reset values; with no new writes, tx_start_en stays 0 for 100 cycles.
